// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory-port arbiter slice:
//   - default widths for requester count, Mem address and Mem data
//   - response-stage record carried from a grant to its completion pulse
//   - small index helper used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_DATA_WIDTH = 32;

   // The id field is sized for the largest legal requester count so the one
   // record type serves every legal NUM_REQ; narrower indices are zero-extended.
   localparam int MAX_NUM_REQ = 8;
   localparam int RSP_ID_W    = $clog2(MAX_NUM_REQ);

   typedef struct packed {
      logic                pending;
      logic [RSP_ID_W-1:0] id;
      logic                we;
   } rsp_stage_t;

   // Index after idx, wrapping at n (n need not be a power of two).
   function automatic int wrap_inc(input int idx, input int n);
      int res;
      if (idx >= n - 1) begin
         res = 0;
      end else begin
         res = idx + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority select. Scans valid starting at rr_ptr, wrapping modulo N,
// and grants the first set bit. Purely combinational.
// Ports:
//   valid     [N]      request vector
//   rr_ptr    [IDX_W]  highest-priority index this cycle (always < N)
//   grant     [N]      one-hot grant, all zero when nothing is valid
//   grant_idx [IDX_W]  binary index of the granted requester (0 if none)
//   grant_any          a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] cand_s;
   logic             hit_s;

   // Priority scan from rr_ptr; the first valid candidate wins, later ones are masked.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand_s    = '0;
      hit_s     = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand_s        = IDX_W'((int'(rr_ptr) + k) % N);
         hit_s         = valid[cand_s] & ~grant_any;
         // each candidate index is visited exactly once per scan
         grant[cand_s] = hit_s;
         grant_idx     = hit_s ? cand_s : grant_idx;
         grant_any     = grant_any | hit_s;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port Mem among NUM_REQ requesters with round-robin
// priority, one access per cycle and a fixed one-cycle response latency.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_we [NUM_REQ]     per-requester request and write flag
//   req_addr  [NUM_REQ*ADDR_WIDTH] packed addresses, slice i = requester i
//   req_wdata [NUM_REQ*DATA_WIDTH] packed write data, slice i = requester i
//   req_ready [NUM_REQ]            one-hot grant (combinational)
//   rsp_valid [NUM_REQ]            completion pulse, one cycle after grant
//   rsp_rdata [DATA_WIDTH]         read data for read completions, else 0
//   mem_en/mem_we/mem_addr/mem_wdata  Mem port drive, zero when idle
//   mem_rdata [DATA_WIDTH]         Mem read data, valid the cycle after a read
//   busy                           any request present or response pending
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic                          mem_we,
   output logic                          mem_en,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    grant_s;
   logic [IDX_W-1:0]      grant_idx_s;
   logic                  grant_any_s;
   logic [IDX_W-1:0]      rr_ptr_r;
   logic [IDX_W-1:0]      rr_ptr_next_s;
   rsp_stage_t            rsp_r;
   rsp_stage_t            rsp_next_s;
   logic [NUM_REQ-1:0]    rsp_valid_s;
   logic [DATA_WIDTH-1:0] rsp_rdata_s;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   assign req_ready = grant_s;

   // Mem port steering: pass the granted slices straight through, park at zero when idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_any_s) begin
         mem_en    = 1'b1;
         mem_we    = req_we[grant_idx_s];
         mem_addr  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wdata = req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Next pointer and next response record; both hold/clear when nothing is granted.
   always_comb begin
      rr_ptr_next_s = rr_ptr_r;
      rsp_next_s    = '0;
      if (grant_any_s) begin
         rr_ptr_next_s      = IDX_W'(wrap_inc(int'(grant_idx_s), NUM_REQ));
         rsp_next_s.pending = 1'b1;
         rsp_next_s.id      = RSP_ID_W'(grant_idx_s);
         rsp_next_s.we      = req_we[grant_idx_s];
      end else begin
         rsp_next_s.pending = 1'b0;
      end
   end

   // State registers: round-robin pointer and response stage. Reset drops any in-flight response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
         rsp_r    <= '0;
      end else begin
         rr_ptr_r <= rr_ptr_next_s;
         rsp_r    <= rsp_next_s;
      end
   end

   // Response decode. rdata is a direct path from mem_rdata because Mem presents
   // read data exactly in the response cycle; it is gated to zero for writes/idle.
   always_comb begin
      rsp_valid_s = '0;
      rsp_rdata_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid_s[i] = rsp_r.pending & (rsp_r.id == RSP_ID_W'(i));
      end
      if (rsp_r.pending && !rsp_r.we) begin
         rsp_rdata_s = mem_rdata;
      end else begin
         rsp_rdata_s = '0;
      end
   end

   assign rsp_valid = rsp_valid_s;
   assign rsp_rdata = rsp_rdata_s;
   assign busy      = (|req_valid) | rsp_r.pending;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (4 requesters, 16-bit address,
// 32-bit data). A behavioural Mem answers the DUT's port; a request-level
// model (grant by rotating scan, shadow memory, one-deep response slot)
// predicts every output.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_we;
   logic [AW-1:0]     a_addr  [N];
   logic [DW-1:0]     a_wdata [N];
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_we;
   logic              mem_en;
   logic [DW-1:0]     mem_rdata;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_addr[i*AW +: AW]  = a_addr[i];
      assign req_wdata[i*DW +: DW] = a_wdata[i];
   end

   mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_en    (mem_en),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Background contents for never-written locations
   function automatic logic [DW-1:0] init_word(input int a);
      return {16'h5A00 ^ 16'(a * 7), 16'(a)};
   endfunction

   // Behavioural single-port Mem: synchronous write, read data one cycle later
   logic [DW-1:0] env_mem [0:65535];
   bit            env_wr  [0:65535];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
         end else begin
            mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_word(int'(mem_addr));
         end
      end
   end

   // ---------------- reference model ----------------
   int            m_ptr;
   bit            m_pend;
   int            m_id;
   bit            m_we;
   logic [DW-1:0] m_data;
   logic [DW-1:0] shadow [int];

   function automatic logic [DW-1:0] shadow_read(input int a);
      return shadow.exists(a) ? shadow[a] : init_word(a);
   endfunction

   // first requester at m_ptr, m_ptr+1, ... (mod N) that is asking
   function automatic int model_grant();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g = model_grant();
      return (g < 0) ? '0 : (N'(1) << g);
   endfunction

   function automatic logic [AW+DW+1:0] exp_port();
      int g = model_grant();
      if (g < 0) return '0;
      return {1'b1, req_we[g], a_addr[g], a_wdata[g]};
   endfunction

   function automatic logic [N-1:0] exp_rsp_valid();
      return m_pend ? (N'(1) << m_id) : '0;
   endfunction

   function automatic logic [DW-1:0] exp_rsp_rdata();
      return (m_pend && !m_we) ? m_data : '0;
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_pend = 0;
   endtask

   // One clock: model consumes this cycle's grant at the edge, then returns at negedge
   task automatic advance();
      int g;
      g = model_grant();
      @(posedge clk);
      if (g >= 0) begin
         if (req_we[g]) shadow[int'(a_addr[g])] = a_wdata[g];
         else           m_data = shadow_read(int'(a_addr[g]));
      end
      if (!rst_n) begin
         model_reset();
      end else if (g >= 0) begin
         m_pend = 1;
         m_id   = g;
         m_we   = req_we[g];
         m_ptr  = (g + 1) % N;
      end else begin
         m_pend = 0;
      end
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit v, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_we[i]    = we;
      a_addr[i]    = a;
      a_wdata[i]   = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      clear_all();
      model_reset();
      @(negedge clk);
      #1;
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
      n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if ({req_ready, mem_en, mem_we} !== 6'b0) begin n_fail++; $display("FAIL reset_idle_port got ready=%b en=%b we=%b exp all 0", req_ready, mem_en, mem_we); end
      // combinational path still arbitrates with pointer 0 while in reset
      set_req(1, 1'b1, 1'b0, 16'h0010, 32'h0);
      set_req(2, 1'b1, 1'b0, 16'h0020, 32'h0);
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_comb_ready got %b exp 0010", req_ready); end
      n_tests++; if (mem_addr !== 16'h0010 || mem_en !== 1'b1) begin n_fail++; $display("FAIL reset_comb_port got addr=%h en=%b exp 0010/1", mem_addr, mem_en); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_req got %b exp 1", busy); end
      advance();
      #1;
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_no_rsp got %b exp 0000", rsp_valid); end
      clear_all();
      rst_n = 1'b1;
      advance();
   endtask

   task automatic test_single_read();
      set_req(1, 1'b1, 1'b0, 16'h0040, 32'h0);
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_read_ready got %b exp 0010", req_ready); end
      n_tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin n_fail++; $display("FAIL single_read_port got en=%b we=%b addr=%h exp 1/0/0040", mem_en, mem_we, mem_addr); end
      advance();
      clear_all();
      #1;
      n_tests++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL single_read_rsp_valid got %b exp 0010", rsp_valid); end
      n_tests++; if (rsp_rdata !== init_word(32'h0040)) begin n_fail++; $display("FAIL single_read_rdata got %h exp %h", rsp_rdata, init_word(32'h0040)); end
      advance();
      #1;
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_read_pulse_width got %b exp 0000", rsp_valid); end
   endtask

   task automatic test_write_readback();
      set_req(3, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF);
      #1;
      n_tests++; if ({req_ready, mem_we, mem_wdata} !== {4'b1000, 1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_grant got ready=%b we=%b wdata=%h exp 1000/1/deadbeef", req_ready, mem_we, mem_wdata); end
      advance();
      set_req(3, 1'b1, 1'b0, 16'h0100, 32'h0);
      #1;
      n_tests++; if ({rsp_valid, rsp_rdata} !== {4'b1000, 32'h0}) begin n_fail++; $display("FAIL wr_rsp got valid=%b rdata=%h exp 1000/0", rsp_valid, rsp_rdata); end
      n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rd_back_to_back_ready got %b exp 1000", req_ready); end
      advance();
      clear_all();
      #1;
      n_tests++; if ({rsp_valid, rsp_rdata} !== {4'b1000, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_back_rsp got valid=%b rdata=%h exp 1000/deadbeef", rsp_valid, rsp_rdata); end
      advance();
   endtask

   task automatic test_round_robin();
      int cnt [N];
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         set_req(i, 1'b1, 1'b0, AW'(16'h0200 + i), 32'h0);
         cnt[i] = 0;
      end
      advance();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         n_tests++; if (req_ready !== (N'(1) << (c % N)) || mem_en !== 1'b1) begin n_fail++; $display("FAIL rr_order c=%0d got ready=%b en=%b exp %b/1", c, req_ready, mem_en, N'(1) << (c % N)); end
         n_tests++; if (rsp_valid !== ((c == 0) ? 4'b0000 : (N'(1) << ((c - 1) % N)))) begin n_fail++; $display("FAIL rr_rsp c=%0d got %b", c, rsp_valid); end
         n_tests++; if (rsp_rdata !== ((c == 0) ? 32'h0 : init_word(32'h0200 + (c - 1) % N))) begin n_fail++; $display("FAIL rr_rdata c=%0d got %h", c, rsp_rdata); end
         for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
         advance();
      end
      for (int i = 0; i < N; i++) begin
         n_tests++; if (cnt[i] != 3) begin n_fail++; $display("FAIL rr_count req%0d got %0d exp 3", i, cnt[i]); end
      end
      clear_all();
      advance();
   endtask

   task automatic test_ptr_priority();
      set_req(1, 1'b1, 1'b0, 16'h0300, 32'h0);
      advance();                        // grant 1 -> pointer 2
      set_req(0, 1'b1, 1'b0, 16'h0301, 32'h0);
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ptr2_wrap_grant got %b exp 0001", req_ready); end
      advance();                        // grant 0 -> pointer 1
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL ptr1_grant got %b exp 0010", req_ready); end
      advance();
      clear_all();
      advance();
   endtask

   task automatic test_reset_mid();
      set_req(2, 1'b1, 1'b0, 16'h0400, 32'h0);
      #1;
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant got %b exp 0100", req_ready); end
      advance();
      clear_all();
      rst_n = 1'b0;
      #1;
      n_tests++; if ({rsp_valid, rsp_rdata} !== {4'b0000, 32'h0}) begin n_fail++; $display("FAIL midrst_drop got valid=%b rdata=%h exp 0000/0", rsp_valid, rsp_rdata); end
      advance();
      rst_n = 1'b1;
      #1;
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_after got %b exp 0000", rsp_valid); end
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(16'h0410 + i), 32'h0);
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr0 got %b exp 0001", req_ready); end
      advance();
      clear_all();
      advance();
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         #1;
         n_tests++; if ({mem_en, mem_we, busy, rsp_valid, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL idle c=%0d got en=%b we=%b busy=%b rsp=%b addr=%h wdata=%h exp all 0", c, mem_en, mem_we, busy, rsp_valid, mem_addr, mem_wdata); end
         advance();
      end
   endtask

   task automatic test_random();
      int wait_cnt [N];
      int g;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         end
         #1;
         n_tests++; if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {exp_ready(), exp_port()}) begin n_fail++; $display("FAIL rand_req c=%0d got ready=%b en=%b we=%b addr=%h wdata=%h exp ready=%b port=%h", c, req_ready, mem_en, mem_we, mem_addr, mem_wdata, exp_ready(), exp_port()); end
         n_tests++; if ({rsp_valid, rsp_rdata, busy} !== {exp_rsp_valid(), exp_rsp_rdata(), (|req_valid) | m_pend}) begin n_fail++; $display("FAIL rand_rsp c=%0d got valid=%b rdata=%h busy=%b exp valid=%b rdata=%h", c, rsp_valid, rsp_rdata, busy, exp_rsp_valid(), exp_rsp_rdata()); end
         g = model_grant();
         for (int i = 0; i < N; i++) if (req_valid[i]) wait_cnt[i]++;
         if (g >= 0) begin
            n_tests++; if (wait_cnt[g] > N) begin n_fail++; $display("FAIL rand_fairness req%0d waited %0d exp <= %0d", g, wait_cnt[g], N); end
            wait_cnt[g] = 0;
         end
         advance();
         if (g >= 0) begin
            // granted requester either drops or issues a fresh back-to-back request
            if ($urandom_range(0, 1) == 0) set_req(g, 1'b0, 1'b0, '0, '0);
            else set_req(g, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         end
      end
      clear_all();
      advance();
      advance();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_readback();
      test_round_robin();
      test_ptr_priority();
      test_reset_mid();
      test_idle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the single Mem RW port; legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 16: Mem word-address width.
REQ-003 Parameter DATA_WIDTH, default 32: Mem data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock; the Mem port runs on the same clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester access request.
REQ-008 req_we  input  NUM_REQ  per-requester write (1) or read (0).
REQ-009 req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
REQ-010 req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data; requester i uses slice i.
REQ-011 req_ready  output  NUM_REQ  one-hot grant; handshake on valid[i]&ready[i].
REQ-012 rsp_valid  output  NUM_REQ  one-cycle completion pulse to the requester that was granted.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data, shared by all requesters, qualified by rsp_valid.
REQ-014 mem_addr / mem_wdata  output  ADDR_WIDTH / DATA_WIDTH  drive Mem addr0 / write_data.
REQ-015 mem_we  output  1  drives Mem write_en.
REQ-016 mem_en  output  1  drives Mem port clock enable.
REQ-017 mem_rdata  input  DATA_WIDTH  Mem read_data; valid one cycle after a read access.
REQ-018 busy  output  1  high when any req_valid is high or a response is pending.

Function
REQ-019 Grant SHALL be round-robin: the first requester with req_valid=1 at index rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
REQ-020 req_ready SHALL be combinational from req_valid and rr_ptr, with at most one bit set, and with no bit set when no req_valid is high.
REQ-021 In a grant cycle, mem_en=1, and mem_addr, mem_wdata and mem_we SHALL equal the granted requester's slices in the same cycle.
REQ-022 In a cycle with no grant, mem_en=0, mem_we=0, and mem_addr=0 and mem_wdata=0.
REQ-023 On a grant to index g, rr_ptr SHALL update to (g+1) mod NUM_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-024 A response pipeline register SHALL capture {pending=1, id=g, we} on a grant and pending=0 otherwise.
REQ-025 Exactly one cycle after a grant, rsp_valid[id] SHALL be 1, giving fixed latency 1 for both reads and writes.
REQ-026 For a read response, rsp_rdata SHALL equal mem_rdata; for a write response or no response, rsp_rdata SHALL be 0.
REQ-027 Throughput SHALL be one access per cycle: a grant is permitted in the same cycle as a response to any requester, including the same one.
REQ-028 Fairness: a requester holding req_valid continuously SHALL be granted within NUM_REQ cycles.
REQ-029 Requesters SHALL hold their valid, we, addr and wdata until ready; the block does not register request fields.

Reset
REQ-030 When rst_n=0, rr_ptr=0 and pending=0, so rsp_valid=0, rsp_rdata=0 and busy reflects only req_valid.
REQ-031 A reset asserted between a grant and its response SHALL drop that response; no rsp_valid pulse follows reset.
REQ-032 Combinational outputs (req_ready, mem_*) SHALL follow REQ-019 to REQ-022 during reset using rr_ptr=0.

Structure
REQ-033 A shared package SHALL hold the default widths and a response-stage struct {pending, id[$clog2(NUM_REQ)-1:0], we}.
REQ-034 One sub-module, rr_arbiter, SHALL implement the rotating priority select (inputs: valid and rr_ptr; outputs: one-hot grant and index); the pipeline stays in the top.

Verification
REQ-035 Single read: req_valid=4'b0010, we=0, addr1=0x0040 -> same cycle ready=4'b0010, mem_addr=0x0040, mem_en=1; next cycle rsp_valid=4'b0010 and rsp_rdata=Mem[0x0040].
REQ-036 Write then read-back: requester 3 writes 0xDEADBEEF to 0x0100 and then reads 0x0100 -> two consecutive rsp_valid[3] pulses, the second with rsp_rdata=0xDEADBEEF.
REQ-037 All four requesters valid continuously from reset -> grant order 0,1,2,3,0,...; each requester is granted exactly once per 4 cycles, with mem_en=1 every cycle.
REQ-038 rr_ptr=2 with req_valid=4'b0011 -> grant 0; rr_ptr then becomes 1.
REQ-039 Reset mid-operation: rst_n pulsed low in the cycle after a read grant -> no rsp_valid, and rr_ptr=0 after release.
REQ-040 Idle: req_valid=0 for 10 cycles -> mem_en=0, mem_we=0, busy=0 and rsp_valid=0 throughout.
